// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly with a 4-stage valid-qualified pipeline.
// top = even + twi*odd, btm = even - twi*odd, with per-sample scale/inverse
// mode, saturation to W bits, a sticky overflow flag and a sideband tag.
module butterfly_pipe #(
  parameter int W     = 16,
  parameter int TW    = 16,
  parameter int TAG_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic                i_scale,
  input  logic                i_inv,
  input  logic [TAG_W-1:0]    i_tag,
  input  logic signed [W-1:0] i_even_re,
  input  logic signed [W-1:0] i_even_im,
  input  logic signed [W-1:0] i_odd_re,
  input  logic signed [W-1:0] i_odd_im,
  input  logic signed [TW-1:0] i_twi_re,
  input  logic signed [TW-1:0] i_twi_im,
  input  logic                i_clr_ovf,
  output logic                o_valid,
  output logic [TAG_W-1:0]    o_tag,
  output logic signed [W-1:0] o_top_re,
  output logic signed [W-1:0] o_top_im,
  output logic signed [W-1:0] o_btm_re,
  output logic signed [W-1:0] o_btm_im,
  output logic                o_ovf
);
  localparam int PW = W + TW + 1;
  // Rounding constant 2^(TW-2) at product-sum width.
  localparam logic signed [PW:0] RND = {{(PW - TW + 2){1'b0}}, 1'b1, {(TW - 2){1'b0}}};
  localparam logic signed [W+1:0] ONE  = {{(W + 1){1'b0}}, 1'b1};
  localparam logic signed [W+1:0] SMAX = {3'b000, {(W - 1){1'b1}}};
  localparam logic signed [W+1:0] SMIN = {3'b111, {(W - 1){1'b0}}};

  // Optional halving with round half-up.
  function automatic logic signed [W+1:0] scale_fn(input logic signed [W+1:0] x, input logic s);
    if (s) scale_fn = (x + ONE) >>> 1;
    else   scale_fn = x;
  endfunction

  // Saturate to W bits; MSB of the result flags that clipping happened.
  function automatic logic [W:0] sat_fn(input logic signed [W+1:0] x);
    if (x > SMAX)      sat_fn = {1'b1, 1'b0, {(W - 1){1'b1}}};
    else if (x < SMIN) sat_fn = {1'b1, 1'b1, {(W - 1){1'b0}}};
    else               sat_fn = {1'b0, x[W-1:0]};
  endfunction

  logic [2:0] vld;

  logic signed [W-1:0]  s1_er, s1_ei, s1_ar, s1_ai;
  logic signed [TW:0]   s1_br, s1_bi;
  logic                 s1_scale;
  logic [TAG_W-1:0]     s1_tag;
  logic signed [TW:0]   twi_im_ext, twi_im_sel;

  logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
  logic signed [W-1:0]  s2_er, s2_ei;
  logic                 s2_scale;
  logic [TAG_W-1:0]     s2_tag;

  logic signed [PW:0]   re_full, im_full;
  logic signed [W:0]    s3_re, s3_im;
  logic signed [W-1:0]  s3_er, s3_ei;
  logic                 s3_scale;
  logic [TAG_W-1:0]     s3_tag;

  logic [W:0]           sat_tr, sat_ti, sat_br, sat_bi;
  logic                 sat_any;
  logic                 unused_bits;

  // Sign-extend the twiddle imaginary part and conjugate it for inverse mode.
  always_comb begin
    twi_im_ext = {i_twi_im[TW-1], i_twi_im};
    if (i_inv) twi_im_sel = -twi_im_ext;
    else       twi_im_sel = twi_im_ext;
  end

  // Valid shift register and output valid; frozen while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld     <= 3'b000;
      o_valid <= 1'b0;
    end else if (i_en) begin
      vld     <= {vld[1:0], i_valid};
      o_valid <= vld[2];
    end
  end

  // Stage 1: capture the input sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_er <= '0; s1_ei <= '0; s1_ar <= '0; s1_ai <= '0;
      s1_br <= '0; s1_bi <= '0; s1_scale <= 1'b0; s1_tag <= '0;
    end else if (i_en && i_valid) begin
      s1_er <= i_even_re; s1_ei <= i_even_im;
      s1_ar <= i_odd_re;  s1_ai <= i_odd_im;
      s1_br <= {i_twi_re[TW-1], i_twi_re};
      s1_bi <= twi_im_sel;
      s1_scale <= i_scale; s1_tag <= i_tag;
    end
  end

  // Stage 2: the four partial products; even operand delayed alongside.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_rr <= '0; s2_ii <= '0; s2_ri <= '0; s2_ir <= '0;
      s2_er <= '0; s2_ei <= '0; s2_scale <= 1'b0; s2_tag <= '0;
    end else if (i_en && vld[0]) begin
      s2_rr <= PW'(s1_ar) * PW'(s1_br);
      s2_ii <= PW'(s1_ai) * PW'(s1_bi);
      s2_ri <= PW'(s1_ar) * PW'(s1_bi);
      s2_ir <= PW'(s1_ai) * PW'(s1_br);
      s2_er <= s1_er; s2_ei <= s1_ei;
      s2_scale <= s1_scale; s2_tag <= s1_tag;
    end
  end

  // Complex product sums with round half-up ahead of the Q-format shift.
  always_comb begin
    re_full = (PW + 1)'(s2_rr) - (PW + 1)'(s2_ii) + RND;
    im_full = (PW + 1)'(s2_ri) + (PW + 1)'(s2_ir) + RND;
  end

  // Stage 3: keep W+1 bits of the rounded product (magnitude stays below 2^W).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s3_re <= '0; s3_im <= '0; s3_er <= '0; s3_ei <= '0;
      s3_scale <= 1'b0; s3_tag <= '0;
    end else if (i_en && vld[1]) begin
      s3_re <= re_full[TW-1 +: W+1];
      s3_im <= im_full[TW-1 +: W+1];
      s3_er <= s2_er; s3_ei <= s2_ei;
      s3_scale <= s2_scale; s3_tag <= s2_tag;
    end
  end

  // Discarded fraction and guard bits of the product sums.
  assign unused_bits = ^{re_full[PW:PW-1], re_full[TW-2:0], im_full[PW:PW-1], im_full[TW-2:0]};

  // Sum/difference, optional scaling and saturation for the output stage.
  always_comb begin
    sat_tr  = sat_fn(scale_fn((W + 2)'(s3_er) + (W + 2)'(s3_re), s3_scale));
    sat_ti  = sat_fn(scale_fn((W + 2)'(s3_ei) + (W + 2)'(s3_im), s3_scale));
    sat_br  = sat_fn(scale_fn((W + 2)'(s3_er) - (W + 2)'(s3_re), s3_scale));
    sat_bi  = sat_fn(scale_fn((W + 2)'(s3_ei) - (W + 2)'(s3_im), s3_scale));
    sat_any = sat_tr[W] | sat_ti[W] | sat_br[W] | sat_bi[W];
  end

  // Stage 4: registered results and tag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_top_re <= '0; o_top_im <= '0; o_btm_re <= '0; o_btm_im <= '0;
      o_tag <= '0;
    end else if (i_en && vld[2]) begin
      o_top_re <= sat_tr[W-1:0]; o_top_im <= sat_ti[W-1:0];
      o_btm_re <= sat_br[W-1:0]; o_btm_im <= sat_bi[W-1:0];
      o_tag    <= s3_tag;
    end
  end

  // Sticky overflow: a new saturation beats a simultaneous clear; clear ignores stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      o_ovf <= 1'b0;
    else if (i_en && vld[2] && sat_any) o_ovf <= 1'b1;
    else if (i_clr_ovf)                o_ovf <= 1'b0;
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed self-checking bench for butterfly_pipe (W=TW=16, TAG_W=8).
module tb_butterfly_pipe;
  logic               i_clk = 1'b0;
  logic               i_rst_n, i_en, i_valid, i_scale, i_inv, i_clr_ovf;
  logic [7:0]         i_tag;
  logic signed [15:0] i_even_re, i_even_im, i_odd_re, i_odd_im, i_twi_re, i_twi_im;
  logic               o_valid, o_ovf;
  logic [7:0]         o_tag;
  logic signed [15:0] o_top_re, o_top_im, o_btm_re, o_btm_im;

  int pass_cnt = 0;
  int total_cnt = 0;

  butterfly_pipe #(.W(16), .TW(16), .TAG_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_valid(i_valid),
    .i_scale(i_scale), .i_inv(i_inv), .i_tag(i_tag),
    .i_even_re(i_even_re), .i_even_im(i_even_im),
    .i_odd_re(i_odd_re), .i_odd_im(i_odd_im),
    .i_twi_re(i_twi_re), .i_twi_im(i_twi_im),
    .i_clr_ovf(i_clr_ovf), .o_valid(o_valid), .o_tag(o_tag),
    .o_top_re(o_top_re), .o_top_im(o_top_im),
    .o_btm_re(o_btm_re), .o_btm_im(o_btm_im), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", name, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_in(input int er, input int ei, input int odr, input int odi,
                        input int tr, input int ti, input logic sc, input logic inv, input int tag);
    i_even_re = 16'(er); i_even_im = 16'(ei);
    i_odd_re  = 16'(odr); i_odd_im = 16'(odi);
    i_twi_re  = 16'(tr); i_twi_im  = 16'(ti);
    i_scale = sc; i_inv = inv; i_tag = 8'(tag);
    i_valid = 1'b1;
  endtask

  // One sample through an otherwise empty pipe, checking exact 4-edge latency.
  task automatic run_one(input int er, input int ei, input int odr, input int odi,
                         input int tr, input int ti, input logic sc, input logic inv, input int tag);
    set_in(er, ei, odr, odi, tr, ti, sc, inv, tag);
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    chk("lat_not_yet", o_valid, 0);
    tick();
    chk("lat_valid", o_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv;
    logic prev_ov;
    logic [15:0] pat;
    logic en_c;
    int exp_ti[4];
    int exp_bi[4];
    logic m_sc[4];
    logic m_inv[4];

    i_rst_n = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_scale = 1'b0; i_inv = 1'b0;
    i_clr_ovf = 1'b0; i_tag = 8'd0;
    i_even_re = 16'sd0; i_even_im = 16'sd0; i_odd_re = 16'sd0; i_odd_im = 16'sd0;
    i_twi_re = 16'sd0; i_twi_im = 16'sd0;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_top_re", o_top_re, 0);
    chk("rst_tag", o_tag, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();

    // 1: scaled real butterfly
    run_one(1000, 0, 2000, 0, 32767, 0, 1'b1, 1'b0, 1);
    chk("t1_top_re", o_top_re, 1500);
    chk("t1_top_im", o_top_im, 0);
    chk("t1_btm_re", o_btm_re, -500);
    chk("t1_btm_im", o_btm_im, 0);
    chk("t1_ovf", o_ovf, 0);
    chk("t1_tag", o_tag, 1);

    // 2: twiddle -j, forward then inverse
    run_one(0, 0, 2000, 0, 0, -32768, 1'b0, 1'b0, 2);
    chk("t2f_top_re", o_top_re, 0);
    chk("t2f_top_im", o_top_im, -2000);
    chk("t2f_btm_im", o_btm_im, 2000);
    run_one(0, 0, 2000, 0, 0, -32768, 1'b0, 1'b1, 3);
    chk("t2i_top_im", o_top_im, 2000);
    chk("t2i_btm_im", o_btm_im, -2000);

    // 3: saturation and sticky overflow; rounded product is 29999
    run_one(30000, 0, 30000, 0, 32767, 0, 1'b0, 1'b0, 4);
    chk("t3_top_re_sat", o_top_re, 32767);
    chk("t3_btm_re", o_btm_re, 1);
    chk("t3_ovf_set", o_ovf, 1);
    run_one(1000, 0, 2000, 0, 32767, 0, 1'b1, 1'b0, 5);
    chk("t3_ovf_sticky", o_ovf, 1);
    i_en = 1'b0;
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    chk("t3_clr_while_stalled", o_ovf, 0);
    chk("t3_valid_held", o_valid, 1);
    i_en = 1'b1;
    set_in(30000, 0, 30000, 0, 32767, 0, 1'b0, 1'b0, 6);
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    chk("t3_set_wins", o_ovf, 1);
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    chk("t3_clr", o_ovf, 0);
    run_one(30000, 0, 30000, 0, 32767, 0, 1'b1, 1'b0, 7);
    chk("t3s_top_re", o_top_re, 30000);
    chk("t3s_btm_re", o_btm_re, 1);
    chk("t3s_ovf", o_ovf, 0);

    // 5: per-sample modes back to back: (sc,inv) = 00, 11, 10, 01
    m_sc  = '{1'b0, 1'b1, 1'b1, 1'b0};
    m_inv = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_ti = '{-2000, 1000, -1000, 2000};
    exp_bi = '{2000, -1000, 1000, -2000};
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 2000, 0, 0, -32768, m_sc[k], m_inv[k], 20 + k);
      tick();
    end
    i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t5_valid", o_valid, 1);
      chk("t5_top_im", o_top_im, exp_ti[k]);
      chk("t5_btm_im", o_btm_im, exp_bi[k]);
      chk("t5_tag", o_tag, 20 + k);
      tick();
    end
    chk("t5_drained", o_valid, 0);

    // 4: 8 back-to-back samples under a stall pattern
    pat = 16'b1011_0110_1101_1001;
    sent = 0; rcv = 0; prev_ov = o_valid;
    for (int c = 0; c < 200 && rcv < 8; c++) begin
      en_c = pat[c % 16];
      i_en = en_c;
      if (sent < 8) set_in(1000 + 100 * sent, -50 * sent, 10 * sent, 0, 32767, 0, 1'b0, 1'b0, sent);
      else i_valid = 1'b0;
      tick();
      if (en_c && sent < 8) sent++;
      if (en_c) begin
        if (o_valid) begin
          chk("t4_tag", o_tag, rcv);
          chk("t4_top_re", o_top_re, 1000 + 110 * rcv);
          chk("t4_btm_re", o_btm_re, 1000 + 90 * rcv);
          chk("t4_top_im", o_top_im, -50 * rcv);
          rcv++;
        end
      end else begin
        chk("t4_hold", o_valid, prev_ov);
      end
      prev_ov = o_valid;
    end
    i_en = 1'b1;
    i_valid = 1'b0;
    chk("t4_count", rcv, 8);

    // 6: asynchronous reset with samples in flight
    for (int k = 0; k < 5; k++) begin
      set_in(30000, 0, 30000, 0, 32767, 0, 1'b0, 1'b0, 10 + k);
      tick();
    end
    i_valid = 1'b0;
    chk("t6_pre_valid", o_valid, 1);
    chk("t6_pre_ovf", o_ovf, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_valid, 0);
    chk("t6_rst_top_re", o_top_re, 0);
    chk("t6_rst_ovf", o_ovf, 0);
    chk("t6_rst_tag", o_tag, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6_no_valid", o_valid, 0);
    end
    run_one(1000, 0, 2000, 0, 32767, 0, 1'b1, 1'b0, 9);
    chk("t6_after_top_re", o_top_re, 1500);
    chk("t6_after_tag", o_tag, 9);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
